// File: rtl/sha3_wb_bridge.sv
// Wishbone register front-end for the SHA-3 core.
// Buffers message words in a FIFO, streams them to the core over valid/ready,
// captures the digest and raises level interrupts.
// Ports:
//   wb_clk_i, wb_rst_i              clock, async active-high reset
//   wbs_*                           Wishbone classic slave (256-byte window at BASE_ADDR)
//   msg_data_o/last_o/valid_o/ready_i  message stream to the core
//   start_o, mode_o                 start pulse and hash variant
//   digest_i, digest_valid_i        digest from the core
//   irq_o                           {overflow|sel_err, starved, done}
module sha3_wb_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned DIGEST_WORDS = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        wbs_cyc_i,
    input  logic                        wbs_stb_i,
    input  logic                        wbs_we_i,
    input  logic [3:0]                  wbs_sel_i,
    input  logic [31:0]                 wbs_adr_i,
    input  logic [31:0]                 wbs_dat_i,
    output logic                        wbs_ack_o,
    output logic [31:0]                 wbs_dat_o,
    output logic [31:0]                 msg_data_o,
    output logic                        msg_last_o,
    output logic                        msg_valid_o,
    input  logic                        msg_ready_i,
    output logic                        start_o,
    output logic [1:0]                  mode_o,
    input  logic [32*DIGEST_WORDS-1:0]  digest_i,
    input  logic                        digest_valid_i,
    output logic [2:0]                  irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t      state;
    logic        done;
    logic        overflow;
    logic        sel_err;
    logic [2:0]  irq_en;
    logic [31:0] digest_q [DIGEST_WORDS];

    logic [32:0]   fifo_mem [FIFO_DEPTH];
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          fifo_empty;
    logic          fifo_full;

    // Bus decode
    logic       hit, req, wr_req, sel_full;
    logic [7:0] off;
    logic       is_ctrl, is_stat, is_en, is_data, is_last;
    logic       ctrl_wr, do_clear, mode_wr, do_start;
    logic       push_req, push, pop, sel_bad, ovf_set, en_wr, done_set;
    logic [2:0] w1c;
    logic [31:0] rdata;

    assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
    assign wr_req   = req & wbs_we_i;
    assign off      = wbs_adr_i[7:0];
    assign sel_full = (wbs_sel_i == 4'hF);

    assign is_ctrl = (off == 8'h00);
    assign is_stat = (off == 8'h04);
    assign is_en   = (off == 8'h08);
    assign is_data = (off == 8'h0C);
    assign is_last = (off == 8'h10);

    // CLEAR takes priority over START/MODE in the same CTRL write
    assign ctrl_wr  = wr_req & is_ctrl & sel_full;
    assign do_clear = ctrl_wr & wbs_dat_i[3];
    assign mode_wr  = ctrl_wr & ~wbs_dat_i[3] & (state == ST_IDLE);
    assign do_start = mode_wr & wbs_dat_i[0];

    assign sel_bad  = wr_req & (is_ctrl | is_data | is_last) & ~sel_full;
    assign push_req = wr_req & (is_data | is_last) & sel_full;
    assign pop      = msg_valid_o & msg_ready_i;
    // A same-edge pop frees the slot a full FIFO would otherwise refuse
    assign push     = push_req & (~fifo_full | pop);
    assign ovf_set  = push_req & fifo_full & ~pop;
    assign w1c      = (wr_req & is_stat & wbs_sel_i[0]) ? wbs_dat_i[3:1] : 3'b000;
    assign en_wr    = wr_req & is_en & wbs_sel_i[0];
    assign done_set = (state == ST_WAIT) & digest_valid_i & ~do_clear;

    // FIFO status and head
    assign level       = wr_ptr - rd_ptr;
    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (level == LW'(FIFO_DEPTH));
    assign msg_valid_o = (state == ST_ABSORB) & ~fifo_empty;
    assign msg_data_o  = fifo_mem[rd_ptr[AW-1:0]][31:0];
    assign msg_last_o  = fifo_mem[rd_ptr[AW-1:0]][32];

    assign irq_o = {(overflow | sel_err) & irq_en[2],
                    (state == ST_ABSORB) & fifo_empty & irq_en[1],
                    done & irq_en[0]};

    // FSM and start pulse
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            start_o <= 1'b0;
            mode_o  <= 2'd0;
        end else begin
            start_o <= do_start;
            if (mode_wr) mode_o <= wbs_dat_i[2:1];
            if (do_clear) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:   if (do_start) state <= ST_ABSORB;
                    ST_ABSORB: if (pop && msg_last_o) state <= ST_WAIT;
                    ST_WAIT:   if (digest_valid_i) state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    // Message FIFO
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_mem[i] <= '0;
        end else if (do_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= {is_last, wbs_dat_i};
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // Sticky status flags and interrupt enables
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            done     <= 1'b0;
            overflow <= 1'b0;
            sel_err  <= 1'b0;
            irq_en   <= 3'b000;
        end else begin
            if (en_wr) irq_en <= wbs_dat_i[2:0];
            if (do_clear) begin
                done     <= 1'b0;
                overflow <= 1'b0;
                sel_err  <= 1'b0;
            end else begin
                done     <= (done & ~w1c[0]) | done_set;
                overflow <= (overflow & ~w1c[1]) | ovf_set;
                sel_err  <= (sel_err & ~w1c[2]) | sel_bad;
            end
        end
    end

    // Digest capture
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < int'(DIGEST_WORDS); i++) digest_q[i] <= '0;
        end else if (done_set) begin
            for (int i = 0; i < int'(DIGEST_WORDS); i++) digest_q[i] <= digest_i[32*i +: 32];
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        case (off)
            8'h00:   rdata = {28'd0, (state != ST_IDLE), mode_o, 1'b0};
            8'h04:   rdata = {17'd0, 7'(level), 4'd0, sel_err, overflow, done, (state != ST_IDLE)};
            8'h08:   rdata = {29'd0, irq_en};
            default: begin
                for (int i = 0; i < int'(DIGEST_WORDS); i++) begin
                    if (off == 8'(64 + 4*i)) rdata = digest_q[i];
                end
            end
        endcase
    end

    // Bus response: one-cycle ack, read data sampled in the request cycle
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_sha3_wb_bridge.sv
// Scoreboard bench for sha3_wb_bridge: directed bus sequences push expected
// read data, message words and start modes into queues; a negedge monitor
// pops and compares whenever the DUT presents them.
module tb_sha3_wb_bridge;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]        sel = 4'h0;
    logic [31:0]       adr = 32'd0, wdat = 32'd0;
    logic              ack;
    logic [31:0]       rdat;
    logic [31:0]       msg_data;
    logic              msg_last, msg_valid;
    logic              msg_ready = 1'b0;
    logic              start;
    logic [1:0]        mode;
    logic [32*DW-1:0]  digest = '0;
    logic              digest_valid = 1'b0;
    logic [2:0]        irq;

    int total = 0;
    int bad   = 0;

    string       rd_name_q [$];
    logic [31:0] rd_exp_q  [$];
    logic [32:0] msg_exp_q [$];
    logic [1:0]  mode_exp_q[$];

    sha3_wb_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIGEST_WORDS(DW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .msg_data_o(msg_data), .msg_last_o(msg_last), .msg_valid_o(msg_valid),
        .msg_ready_i(msg_ready), .start_o(start), .mode_o(mode),
        .digest_i(digest), .digest_valid_i(digest_valid), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: read data, message stream and start pulses
    string       mon_name;
    logic [31:0] mon_exp;
    logic [32:0] mon_msg;
    always @(negedge clk) begin
        if (ack && !we) begin
            if (rd_name_q.size() == 0) chk("unexpected_read_ack", 32'd1, 32'd0);
            else begin
                mon_name = rd_name_q.pop_front();
                mon_exp  = rd_exp_q.pop_front();
                chk(mon_name, rdat, mon_exp);
            end
        end
        if (msg_valid && msg_ready) begin
            if (msg_exp_q.size() == 0) chk("unexpected_msg_word", 32'd1, 32'd0);
            else begin
                mon_msg = msg_exp_q.pop_front();
                chk("msg_word", {msg_last, msg_data}, 32'(mon_msg));
                chk("msg_last", 32'(msg_last), 32'(mon_msg[32]));
            end
        end
        if (start) begin
            if (mode_exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
            else chk("start_mode", 32'(mode), 32'(mode_exp_q.pop_front()));
        end
    end

    task automatic wb_cycle(input logic w, input logic [7:0] off, input logic [31:0] d,
                            input logic [3:0] s, input bit rdy_now, output int lat);
        bit got;
        @(posedge clk); #1;
        if (rdy_now) msg_ready = 1'b1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | 32'(off); wdat = d; sel = s;
        lat = 0; got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (ack) got = 1; else lat++;
        end
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s = 4'hF);
        int lat;
        wb_cycle(1'b1, off, d, s, 1'b0, lat);
    endtask

    task automatic rd(input string name, input logic [7:0] off, input logic [31:0] exp);
        int lat;
        rd_name_q.push_back(name);
        rd_exp_q.push_back(exp);
        wb_cycle(1'b0, off, 32'd0, 4'hF, 1'b0, lat);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   32'(ack), 32'd0);
        chk({tag, "_rdat"},  rdat, 32'd0);
        chk({tag, "_start"}, 32'(start), 32'd0);
        chk({tag, "_mode"},  32'(mode), 32'd0);
        chk({tag, "_valid"}, 32'(msg_valid), 32'd0);
        chk({tag, "_last"},  32'(msg_last), 32'd0);
        chk({tag, "_data"},  msg_data, 32'd0);
        chk({tag, "_irq"},   32'(irq), 32'd0);
    endtask

    initial begin
        int lat;
        #1;
        chk_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state reads
        rd("status_reset", 8'h04, 32'h0);
        rd("digest0_reset", 8'h40, 32'h0);
        rd_name_q.push_back("unmapped_80");
        rd_exp_q.push_back(32'h0);
        wb_cycle(1'b0, 8'h80, 32'd0, 4'hF, 1'b0, lat);
        chk("unmapped_ack_latency", 32'(lat), 32'd1);

        // Basic 3-word message, MODE=1
        msg_ready = 1'b1;
        wr(8'h0C, 32'h11);
        wr(8'h0C, 32'h22);
        wr(8'h10, 32'h33);
        rd("status_preload", 8'h04, 32'h0000_0300);
        msg_exp_q.push_back({1'b0, 32'h11});
        msg_exp_q.push_back({1'b0, 32'h22});
        msg_exp_q.push_back({1'b1, 32'h33});
        mode_exp_q.push_back(2'd1);
        wr(8'h00, 32'h3);
        repeat (5) @(posedge clk);
        rd("status_wait_digest", 8'h04, 32'h1);
        rd("ctrl_busy_mode1", 8'h00, 32'hA);

        // Digest capture and done interrupt
        wr(8'h08, 32'h1);
        @(posedge clk); #1;
        for (int i = 0; i < DW; i++) digest[32*i +: 32] = 32'hA0 + 32'(i);
        digest_valid = 1'b1;
        @(posedge clk); #1;
        digest_valid = 1'b0;
        chk("irq_done", 32'(irq), 32'h1);
        rd("digest5", 8'h54, 32'hA5);
        rd("status_done", 8'h04, 32'h2);
        wr(8'h04, 32'h2);
        @(negedge clk);
        chk("irq_after_w1c", 32'(irq), 32'h0);
        // Digest outside WAIT_DIGEST must be ignored
        @(posedge clk); #1;
        digest = '1;
        digest_valid = 1'b1;
        @(posedge clk); #1;
        digest_valid = 1'b0;
        rd("digest5_retained", 8'h54, 32'hA5);
        rd("status_no_done", 8'h04, 32'h0);

        // Overflow in IDLE, then CLEAR
        wr(8'h08, 32'h7);
        for (int i = 0; i < 9; i++) wr(8'h0C, 32'h200 + 32'(i));
        rd("status_overflow", 8'h04, 32'h0000_0804);
        chk("irq_overflow", 32'(irq), 32'h4);
        wr(8'h00, 32'h8);
        rd("status_after_clear", 8'h04, 32'h0);
        @(negedge clk);
        chk("irq_after_clear", 32'(irq), 32'h0);

        // ABSORB stalled, fill, push with simultaneous pop
        msg_ready = 1'b0;
        mode_exp_q.push_back(2'd2);
        wr(8'h00, 32'h5);
        @(negedge clk);
        chk("irq_starved", 32'(irq), 32'h2);
        for (int i = 0; i < 8; i++) begin
            wr(8'h0C, 32'h100 + 32'(i));
            msg_exp_q.push_back({1'b0, 32'h100 + 32'(i)});
        end
        rd("status_full_absorb", 8'h04, 32'h0000_0801);
        chk("irq_not_starved", 32'(irq), 32'h0);
        msg_exp_q.push_back({1'b1, 32'h1FF});
        wb_cycle(1'b1, 8'h10, 32'h1FF, 4'hF, 1'b1, lat);
        repeat (12) @(posedge clk);
        rd("status_no_overflow", 8'h04, 32'h1);
        // START and MODE ignored while busy
        wr(8'h00, 32'h1);
        wr(8'h00, 32'h6);
        rd("ctrl_busy_mode2", 8'h00, 32'hC);

        // CLEAR beats START, then byte-lane error
        wr(8'h00, 32'h9);
        wr(8'h0C, 32'h55, 4'h3);
        rd("status_sel_err", 8'h04, 32'h8);
        chk("irq_sel_err", 32'(irq), 32'h4);

        // Reset in the middle of ABSORB with a request outstanding
        wr(8'h00, 32'h8);
        msg_ready = 1'b0;
        wr(8'h10, 32'h77);
        mode_exp_q.push_back(2'd0);
        wr(8'h00, 32'h1);
        @(negedge clk);
        chk("head_valid", 32'(msg_valid), 32'h1);
        chk("head_data", msg_data, 32'h77);
        chk("head_last", 32'(msg_last), 32'h1);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h04; sel = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;
        rd("status_post_reset", 8'h04, 32'h0);
        rd("irq_en_post_reset", 8'h08, 32'h0);
        rd("digest5_post_reset", 8'h54, 32'h0);

        repeat (2) @(posedge clk);
        chk("rd_queue_drained", 32'(rd_name_q.size()), 32'd0);
        chk("msg_queue_drained", 32'(msg_exp_q.size()), 32'd0);
        chk("mode_queue_drained", 32'(mode_exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/sha3_wb_bridge.md
# sha3_wb_bridge

Parametrised Wishbone front-end for the SHA-3 user project: a memory-mapped register block that buffers message words in a FIFO, streams them to the hash core over a valid/ready handshake, captures the digest and raises interrupts. It sits between the management SoC Wishbone bus and the hash datapath inside the user project area. It adds configurable FIFO depth, digest width, mode selection and sticky error reporting.

## Interface
- BASE_ADDR, 32'h3000_0000, base of the 256-byte register window (adr[31:8] match)
- FIFO_DEPTH, 8, message FIFO entries (power of 2, 2..64)
- DIGEST_WORDS, 16, 32-bit digest words captured (1..16)
- wb_clk_i  input  1  clock, all logic on rising edge
- wb_rst_i  input  1  asynchronous, active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle/strobe/write
- wbs_sel_i  input  4  byte lanes
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- msg_data_o  output  32  message word to core
- msg_last_o  output  1  final word of message
- msg_valid_o  output  1  word available
- msg_ready_i  input  1  core accepts word
- start_o  output  1  one-cycle start pulse to core
- mode_o  output  2  hash variant (0:224, 1:256, 2:384, 3:512)
- digest_i  input  32*DIGEST_WORDS  digest from core, word i at bits [32i+31:32i]
- digest_valid_i  input  1  digest_i valid this cycle
- irq_o  output  3  {overflow, starved, done}

## Operation
- Registers (offset from BASE_ADDR):
  - 0x00 CTRL: W bit0 START (pulse), bits[2:1] MODE, bit3 CLEAR (pulse); R {busy, MODE, 0}.
  - 0x04 STATUS: R bit0 busy, bit1 done, bit2 overflow, bit3 sel_err, bits[14:8] FIFO level; W1C on bits[3:1].
  - 0x08 IRQ_EN: RW bits[2:0], byte lane 0 only.
  - 0x0C DATA: W pushes word with last=0. 0x10 DATA_LAST: W pushes word with last=1. Reads return 0.
  - 0x40+4i DIGEST[i], i<DIGEST_WORDS: read-only captured digest. All other offsets read 0, writes ignored; still acknowledged.
- Writes to DATA/DATA_LAST/CTRL with wbs_sel_i != 4'hF: no effect, sel_err set.
- Push while FIFO full: word dropped, overflow set; except a same-edge pop makes room, then push accepted.
- FSM:
  - IDLE: pushes accepted (preload). START moves to ABSORB and pulses start_o with mode_o = MODE.
  - ABSORB: msg_valid_o = FIFO non-empty; pop on msg_valid_o & msg_ready_i. Pop of a last=1 word moves to WAIT_DIGEST.
  - WAIT_DIGEST: digest_valid_i captures all DIGEST_WORDS words, sets done, returns to IDLE.
  - busy = state != IDLE. START while busy ignored. MODE write while busy ignored. digest_valid_i outside WAIT_DIGEST ignored.
- CLEAR: flush FIFO, clear done/overflow/sel_err, state to IDLE; digest registers retained; CLEAR wins over START in same write.
- irq_o[0] = done & en0; irq_o[1] = ABSORB & FIFO empty & en1; irq_o[2] = (overflow|sel_err) & en2. Level, derived from registered state.

## Timing
- Request in cycle N (cyc & stb & !ack): side-effects at the edge ending N; wbs_ack_o high for exactly cycle N+1, with read data registered (value sampled in N). Ack then low at least one cycle; max one access per 2 cycles.
- start_o high in cycle N+1 of the START write; first msg_valid_o possible the same cycle if FIFO non-empty.
- FIFO: msg_data_o/msg_last_o are head entry, valid combinationally from registered pointers; pop latency zero; level updates the edge after push/pop.
- Digest captured and done set on the edge where digest_valid_i is high; STATUS read in a following request sees done=1.
- Reset: wbs_ack_o=0, wbs_dat_o=0, start_o=0, mode_o=0, msg_valid_o=0, msg_last_o=0, msg_data_o=0, irq_o=0, FIFO empty, state IDLE, all registers and digest 0. Reset mid-transfer aborts the access with no ack.

## Test plan
- Reset, read STATUS -> 0x0000_0000; read DIGEST[0] -> 0; unmapped 0x80 read -> 0, acked in 1 cycle.
- Push 3 words (0x11,0x22,DATA_LAST 0x33), MODE=1, START, msg_ready_i=1 -> start_o pulse, words 0x11,0x22,0x33 in consecutive cycles, last only on 0x33, mode_o=1.
- Drive digest_valid_i with word i = 0xA0+i in WAIT_DIGEST, IRQ_EN=1 -> irq_o=3'b001, DIGEST[5] reads 0xA5, W1C done -> irq_o=0.
- Push FIFO_DEPTH+1 words in IDLE -> level=8, overflow=1, irq_o[2]=1 with en2; CLEAR -> level 0, overflow 0.
- ABSORB with msg_ready_i=0 then FIFO full, push with simultaneous pop -> accepted, no overflow; empty FIFO in ABSORB with en1 -> irq_o[1]=1.
- DATA write with sel=4'h3 -> not pushed, sel_err=1; assert wb_rst_i mid-ABSORB -> all outputs 0 asynchronously.
